nq_mem_arbiter: RTL and testbench
=================================

// Module: nq_mem_arbiter
// PURPOSE
//  Parametrised successor of the CPU memory controller: arbitrates NUM_CH requesters (fetch, load/store,
//  future DMA/debug) onto the single shared tri-state memory bus. Fixed or round-robin priority, one bus
//  access in flight, wait-state stretching via needWait_i, wait timeout, registered read data.
//  Sits between the pipeline stages and the external addr_o/re_o/we_o/data_io bus.
// PARAMETERS
//  ADDR_W     16  bus address width
//  DATA_W     16  bus data width
//  NUM_CH     2   requester channels; ch0 = highest priority in fixed mode
//  PRIO_MODE  0   0 = fixed priority (lowest index wins), 1 = round-robin
//  MAX_WAIT   15  wait cycles tolerated before timeout abort; 0 disables timeout
// PORTS
//  clk         in   1               clock, all state updates on rising edge
//  rst         in   1               synchronous reset, active-high
//  req_i       in   NUM_CH          per-channel request, held until done_o
//  we_i        in   NUM_CH          per-channel write (1) / read (0)
//  addr_i      in   NUM_CH*ADDR_W   per-channel address, ch k at [k*ADDR_W +: ADDR_W]
//  wdata_i     in   NUM_CH*DATA_W   per-channel write data, same packing
//  gnt_o       out  NUM_CH          one-hot: channel owning the bus (high through ACCESS)
//  done_o      out  NUM_CH          one-hot, 1-cycle completion pulse
//  timeout_o   out  NUM_CH          one-hot, 1-cycle pulse alongside done_o on abort
//  rdata_o     out  DATA_W          read data, valid in done_o cycle, held until next read completes
//  busy_o      out  1               state != IDLE
//  addr_o      out  ADDR_W          bus address
//  re_o, we_o  out  1               bus strobes, mutually exclusive
//  data_io     inout DATA_W         driven only while we_o=1, else 'z
//  needWait_i  in   1               bus stall; access completes on first ACCESS cycle it is 0
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, all outputs 0, data_io 'z, wait counter 0. Reset mid-access
//   drops strobes next cycle; no done_o/timeout_o for the aborted access.
//  FSM IDLE: eligible = req_i & ~done_o (a channel pulsed done this cycle is not re-granted even if
//   req still high). If eligible != 0: pick winner, latch ch/addr/we/wdata, -> ACCESS.
//  FSM ACCESS: gnt_o[ch]=1, addr_o=latched addr, re_o=~we, we_o=we, data_io=wdata if we.
//   needWait_i=0 -> rdata_o<=data_io (reads only), done_o[ch]<=1, -> IDLE.
//   needWait_i=1 -> wait_cnt++; if MAX_WAIT!=0 and wait_cnt==MAX_WAIT -> done_o,timeout_o pulse,
//   rdata_o unchanged, -> IDLE.
//  Latency: req seen in IDLE at cycle N -> strobes cycle N+1 -> done_o cycle N+2 (+1 per wait cycle).
//   Max bus throughput: one access per 2 cycles.
//  Round-robin: search starts at ptr; after grant ptr <= (winner+1) mod NUM_CH. Fixed: ptr unused.
//  req_i/addr_i/we_i changes after grant are ignored until done. req dropped before grant = withdrawn.
//  wait_cnt width = $clog2(MAX_WAIT+1), cleared on entry to ACCESS; never wraps (abort first).
//  NUM_CH=1: arbitration degenerates; ptr tied 0.
// STRUCTURE
//  Shared package nq_pkg: memarb_state_t (IDLE, ACCESS), PRIO_FIXED/PRIO_RR constants.
//  Sub-module nq_rr_arbiter: combinational winner pick (eligible, ptr, mode) -> one-hot + index;
//   pointer register lives in nq_mem_arbiter.
// TESTING
//  1 rst; ch1 read 0x0040, needWait_i=0, bus returns 0xBEEF -> re_o cycle N+1, done_o=2'b10 N+2, rdata_o=0xBEEF.
//  2 ch0 write 0x1234 to 0x0010, needWait_i high 3 cycles -> data_io=0x1234, we_o for 4 cycles, done_o[0] once.
//  3 PRIO_MODE=1, both req held continuously -> grants alternate 0,1,0,1; PRIO_MODE=0 -> ch0 starves ch1.
//  4 MAX_WAIT=4, needWait_i stuck 1 -> abort after 4 wait cycles, done_o+timeout_o pulse, rdata_o unchanged.
//  5 rst asserted mid-wait -> re_o/we_o 0 next cycle, data_io 'z, no done_o; fresh req served normally.
//  6 requester holds req through done cycle -> no duplicate grant that cycle; re-granted next IDLE cycle.

Source files
------------

// File: rtl/nq_pkg.sv
// Shared types and constants for the nq memory arbiter slice.
package nq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memarb_state_t;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

endpackage

// File: rtl/nq_mem_arbiter_if.sv
// Requester-side bundle of the memory arbiter: per-channel requests in,
// grant/completion/read data back out.
interface nq_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]        req_i;
  logic [NUM_CH-1:0]        we_i;
  logic [NUM_CH*ADDR_W-1:0] addr_i;
  logic [NUM_CH*DATA_W-1:0] wdata_i;
  logic [NUM_CH-1:0]        gnt_o;
  logic [NUM_CH-1:0]        done_o;
  logic [NUM_CH-1:0]        timeout_o;
  logic [DATA_W-1:0]        rdata_o;
  logic                     busy_o;

  // Arbiter side
  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, done_o, timeout_o, rdata_o, busy_o
  );

  // Requester side
  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, done_o, timeout_o, rdata_o, busy_o
  );
endinterface

// File: rtl/nq_rr_arbiter.sv
// Combinational winner pick. Fixed mode scans from channel 0; round-robin
// mode scans from ptr upward with wrap. The pointer register is owned by
// the caller.
module nq_rr_arbiter
  import nq_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int PRIO_MODE = PRIO_FIXED,
  localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] win_oh,
  output logic [IDX_W-1:0]  win_idx,
  output logic              win_vld
);

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cidx;
  logic             unused_ptr;

  assign unused_ptr = ^ptr;

  // First eligible channel in scan order wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    cidx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (PRIO_MODE == PRIO_RR) cand = {1'b0, ptr} + (IDX_W+1)'(k);
      else                      cand = (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CH)) cand = cand - (IDX_W+1)'(NUM_CH);
      cidx = cand[IDX_W-1:0];
      if (!win_vld && eligible[cidx]) begin
        win_vld      = 1'b1;
        win_idx      = cidx;
        win_oh[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nq_mem_arbiter.sv
// Arbitrates NUM_CH requesters onto one shared tri-state memory bus with a
// single access in flight, wait-state stretching and optional wait timeout.
module nq_mem_arbiter
  import nq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int PRIO_MODE = PRIO_FIXED,
  parameter int MAX_WAIT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  nq_mem_arbiter_if.slave    req_if,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               re_o,
  output logic               we_o,
  inout  wire  [DATA_W-1:0]  data_io,
  input  logic               needWait_i
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WCNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  memarb_state_t     state, state_nxt;
  logic [NUM_CH-1:0] eligible, win_oh, ch_oh;
  logic [IDX_W-1:0]  win_idx, ptr;
  logic              win_vld;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q, rdata_q;
  logic              sel_we, we_q;
  logic [WCNT_W-1:0] wait_cnt;
  logic              timeout_hit;
  logic [NUM_CH-1:0] done_q, timeout_q;

  // A channel completing this cycle is masked so it cannot be re-granted
  // on its own done pulse.
  assign eligible    = req_if.req_i & ~done_q;
  assign timeout_hit = (MAX_WAIT != 0) && (wait_cnt == WCNT_W'(MAX_WAIT));

  nq_rr_arbiter #(.NUM_CH(NUM_CH), .PRIO_MODE(PRIO_MODE)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .win_oh   (win_oh),
    .win_idx  (win_idx),
    .win_vld  (win_vld)
  );

  // Mux the winning channel's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (win_oh[k]) begin
        sel_addr  = req_if.addr_i[k*ADDR_W +: ADDR_W];
        sel_wdata = req_if.wdata_i[k*DATA_W +: DATA_W];
        sel_we    = req_if.we_i[k];
      end
    end
  end

  generate
    if (NUM_CH > 1 && PRIO_MODE == PRIO_RR) begin : g_ptr
      // Round-robin pointer moves just past the last winner.
      always_ff @(posedge clk) begin
        if (rst)                           ptr <= '0;
        else if (state == IDLE && win_vld) ptr <= (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + IDX_W'(1);
      end
    end else begin : g_ptr_tie
      logic unused_idx;
      assign ptr        = '0;
      assign unused_idx = ^win_idx;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: grant when anything is eligible, leave ACCESS on completion or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ACCESS;
      ACCESS:  if (!needWait_i || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request, count wait states, register completion and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_oh     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      done_q    <= '0;
      timeout_q <= '0;
      rdata_q   <= '0;
    end else begin
      done_q    <= '0;
      timeout_q <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            ch_oh    <= win_oh;
            addr_q   <= sel_addr;
            we_q     <= sel_we;
            wdata_q  <= sel_wdata;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (!needWait_i) begin
            if (!we_q) rdata_q <= data_io;
            done_q <= ch_oh;
          end else if (timeout_hit) begin
            done_q    <= ch_oh;
            timeout_q <= ch_oh;
          end else if (MAX_WAIT != 0) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Bus strobes and grant follow the state; nothing is driven outside ACCESS.
  always_comb begin
    req_if.gnt_o = '0;
    addr_o       = '0;
    re_o         = 1'b0;
    we_o         = 1'b0;
    if (state == ACCESS) begin
      req_if.gnt_o = ch_oh;
      addr_o       = addr_q;
      re_o         = ~we_q;
      we_o         = we_q;
    end
  end

  assign data_io          = (state == ACCESS && we_q) ? wdata_q : 'z;
  assign req_if.done_o    = done_q;
  assign req_if.timeout_o = timeout_q;
  assign req_if.rdata_o   = rdata_q;
  assign req_if.busy_o    = (state != IDLE);

endmodule

// File: tb/tb_nq_mem_arbiter.sv
// Directed bench: one fixed-priority arbiter (MAX_WAIT=15) and one round-robin
// arbiter (MAX_WAIT=4). Expected completions are queued at issue time and a
// monitor compares them against every done_o pulse.
module tb_nq_mem_arbiter;
  import nq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nq_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .NUM_CH(2)) if_fx ();
  nq_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .NUM_CH(2)) if_rr ();

  logic [15:0] addr_fx, addr_rr;
  logic        re_fx, we_fx, re_rr, we_rr;
  logic        nw_fx, nw_rr;
  wire  [15:0] data_fx, data_rr;

  nq_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .NUM_CH(2), .PRIO_MODE(PRIO_FIXED), .MAX_WAIT(15)) u_fx (
    .clk(clk), .rst(rst), .req_if(if_fx), .addr_o(addr_fx), .re_o(re_fx), .we_o(we_fx),
    .data_io(data_fx), .needWait_i(nw_fx));

  nq_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .NUM_CH(2), .PRIO_MODE(PRIO_RR), .MAX_WAIT(4)) u_rr (
    .clk(clk), .rst(rst), .req_if(if_rr), .addr_o(addr_rr), .re_o(re_rr), .we_o(we_rr),
    .data_io(data_rr), .needWait_i(nw_rr));

  // Memory model: fixed contents, drives the bus only while a read strobe is up.
  function automatic logic [15:0] mem_rd(logic [15:0] a);
    case (a)
      16'h0040: return 16'hBEEF;
      16'h0020: return 16'h1111;
      16'h0050: return 16'hA5A5;
      16'h0100: return 16'h0C0C;
      16'h0200: return 16'h0D0D;
      default:  return 16'hDEAD;
    endcase
  endfunction

  assign data_fx = re_fx ? mem_rd(addr_fx) : 'z;
  assign data_rr = re_rr ? mem_rd(addr_rr) : 'z;

  typedef struct {
    logic [1:0]  done;
    logic        to;
    logic [15:0] rdata;
  } exp_t;

  exp_t q_fx[$];
  exp_t q_rr[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endfunction

  function automatic void push_fx(logic [1:0] d, logic to, logic [15:0] r);
    exp_t e;
    e.done = d; e.to = to; e.rdata = r;
    q_fx.push_back(e);
  endfunction

  function automatic void push_rr(logic [1:0] d, logic to, logic [15:0] r);
    exp_t e;
    e.done = d; e.to = to; e.rdata = r;
    q_rr.push_back(e);
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (if_fx.done_o != 2'b00) begin
      if (q_fx.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL fx_spurious_done: got done=%b, required no completion", if_fx.done_o);
      end else begin
        e = q_fx.pop_front();
        chk("fx_done",    32'(if_fx.done_o),    32'(e.done));
        chk("fx_timeout", 32'(if_fx.timeout_o), e.to ? 32'(e.done) : 32'd0);
        chk("fx_rdata",   32'(if_fx.rdata_o),   32'(e.rdata));
      end
    end
    if (if_rr.done_o != 2'b00) begin
      if (q_rr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rr_spurious_done: got done=%b, required no completion", if_rr.done_o);
      end else begin
        e = q_rr.pop_front();
        chk("rr_done",    32'(if_rr.done_o),    32'(e.done));
        chk("rr_timeout", 32'(if_rr.timeout_o), e.to ? 32'(e.done) : 32'd0);
        chk("rr_rdata",   32'(if_rr.rdata_o),   32'(e.rdata));
      end
    end
  end

  initial begin
    rst = 1'b1; nw_fx = 1'b0; nw_rr = 1'b0;
    if_fx.req_i = '0; if_fx.we_i = '0; if_fx.addr_i = '0; if_fx.wdata_i = '0;
    if_rr.req_i = '0; if_rr.we_i = '0; if_rr.addr_i = '0; if_rr.wdata_i = '0;
    tick(3);

    // Reset state
    chk("rst_busy",  32'(if_fx.busy_o),  0);
    chk("rst_gnt",   32'(if_fx.gnt_o),   0);
    chk("rst_done",  32'(if_fx.done_o),  0);
    chk("rst_rdata", 32'(if_fx.rdata_o), 0);
    chk("rst_re",    32'(re_fx),         0);
    chk("rst_we",    32'(we_fx),         0);
    chk("rst_addr",  32'(addr_fx),       0);
    chk("rst_rr_busy", 32'(if_rr.busy_o), 0);
    rst = 1'b0;
    tick();

    // ch1 read, no wait: strobe next cycle, done the cycle after
    if_fx.addr_i[16 +: 16] = 16'h0040; if_fx.we_i[1] = 1'b0; if_fx.req_i[1] = 1'b1;
    push_fx(2'b10, 1'b0, 16'hBEEF);
    tick();
    chk("t1_re",   32'(re_fx),       1);
    chk("t1_we",   32'(we_fx),       0);
    chk("t1_gnt",  32'(if_fx.gnt_o), 32'b10);
    chk("t1_addr", 32'(addr_fx),     32'h0040);
    tick();
    chk("t1_re_off", 32'(re_fx), 0);
    if_fx.req_i[1] = 1'b0;
    tick();

    // ch0 write with three wait cycles: four strobe cycles, rdata untouched
    if_fx.addr_i[0 +: 16] = 16'h0010; if_fx.wdata_i[0 +: 16] = 16'h1234;
    if_fx.we_i[0] = 1'b1; if_fx.req_i[0] = 1'b1; nw_fx = 1'b1;
    push_fx(2'b01, 1'b0, 16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_we",   32'(we_fx),   1);
      chk("t2_re",   32'(re_fx),   0);
      chk("t2_data", 32'(data_fx), 32'h1234);
      if (k == 3) nw_fx = 1'b0;
    end
    tick();
    chk("t2_we_off", 32'(we_fx), 0);
    if_fx.req_i[0] = 1'b0; if_fx.we_i[0] = 1'b0;
    tick();

    // Fixed priority: simultaneous requests, ch0 first; the done mask then hands the slot to ch1
    if_fx.addr_i[0 +: 16] = 16'h0100; if_fx.addr_i[16 +: 16] = 16'h0200; if_fx.req_i = 2'b11;
    push_fx(2'b01, 1'b0, 16'h0C0C);
    push_fx(2'b10, 1'b0, 16'h0D0D);
    tick();
    chk("fx_prio_first", 32'(if_fx.gnt_o), 32'b01);
    tick();
    if_fx.req_i[0] = 1'b0;
    tick();
    chk("fx_prio_second", 32'(if_fx.gnt_o), 32'b10);
    tick();
    if_fx.req_i[1] = 1'b0;
    tick();

    // Round-robin, both held: grants alternate 0,1,0,1
    if_rr.addr_i[0 +: 16] = 16'h0100; if_rr.addr_i[16 +: 16] = 16'h0200; if_rr.req_i = 2'b11;
    push_rr(2'b01, 1'b0, 16'h0C0C);
    push_rr(2'b10, 1'b0, 16'h0D0D);
    push_rr(2'b01, 1'b0, 16'h0C0C);
    push_rr(2'b10, 1'b0, 16'h0D0D);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 1) chk("rr_alt_gnt", 32'(if_rr.gnt_o), (k % 4 == 1) ? 32'b01 : 32'b10);
      if (k == 8) if_rr.req_i = 2'b00;
    end
    tick();

    // ch0 alone moves the pointer to 1, so a simultaneous pair then goes to ch1 first
    if_rr.req_i[0] = 1'b1;
    push_rr(2'b01, 1'b0, 16'h0C0C);
    tick();
    chk("rr_single_gnt", 32'(if_rr.gnt_o), 32'b01);
    tick();
    if_rr.req_i[0] = 1'b0;
    tick();
    if_rr.req_i = 2'b11;
    push_rr(2'b10, 1'b0, 16'h0D0D);
    push_rr(2'b01, 1'b0, 16'h0C0C);
    tick();
    chk("rr_ptr_pick", 32'(if_rr.gnt_o), 32'b10);
    tick();
    if_rr.req_i[1] = 1'b0;
    tick();
    chk("rr_ptr_next", 32'(if_rr.gnt_o), 32'b01);
    tick();
    if_rr.req_i[0] = 1'b0;
    tick();

    // MAX_WAIT=4 with the bus stalled: five strobe cycles, then abort with rdata held
    if_rr.addr_i[0 +: 16] = 16'h0300; if_rr.req_i[0] = 1'b1; nw_rr = 1'b1;
    push_rr(2'b01, 1'b1, 16'h0C0C);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("rr_wait_re",   32'(re_rr),        1);
      chk("rr_wait_busy", 32'(if_rr.busy_o), 1);
    end
    tick();
    chk("rr_abort_re", 32'(re_rr), 0);
    if_rr.req_i[0] = 1'b0; nw_rr = 1'b0;
    tick();

    // Requester holds req through its done cycle: not re-granted that cycle, granted the next
    if_fx.addr_i[0 +: 16] = 16'h0020; if_fx.we_i[0] = 1'b0; if_fx.req_i[0] = 1'b1;
    push_fx(2'b01, 1'b0, 16'h1111);
    push_fx(2'b01, 1'b0, 16'h1111);
    tick();
    chk("t6_gnt", 32'(if_fx.gnt_o), 32'b01);
    tick();
    tick();
    chk("t6_no_dup_busy", 32'(if_fx.busy_o), 0);
    chk("t6_no_dup_gnt",  32'(if_fx.gnt_o),  0);
    tick();
    chk("t6_regrant_busy", 32'(if_fx.busy_o), 1);
    chk("t6_regrant_gnt",  32'(if_fx.gnt_o),  32'b01);
    if_fx.req_i[0] = 1'b0;
    tick(2);

    // Reset in the middle of a stalled write: strobes drop, no completion
    if_fx.addr_i[16 +: 16] = 16'h0030; if_fx.wdata_i[16 +: 16] = 16'h5555;
    if_fx.we_i[1] = 1'b1; if_fx.req_i[1] = 1'b1; nw_fx = 1'b1;
    tick();
    chk("t5_pre_we", 32'(we_fx), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_we",    32'(we_fx),         0);
    chk("t5_re",    32'(re_fx),         0);
    chk("t5_busy",  32'(if_fx.busy_o),  0);
    chk("t5_gnt",   32'(if_fx.gnt_o),   0);
    chk("t5_done",  32'(if_fx.done_o),  0);
    chk("t5_rdata", 32'(if_fx.rdata_o), 0);
    if_fx.req_i[1] = 1'b0; if_fx.we_i[1] = 1'b0; nw_fx = 1'b0; rst = 1'b0;
    tick();
    chk("t5_idle", 32'(if_fx.busy_o), 0);

    // Fresh request after reset is served normally
    if_fx.addr_i[0 +: 16] = 16'h0050; if_fx.we_i[0] = 1'b0; if_fx.req_i[0] = 1'b1;
    push_fx(2'b01, 1'b0, 16'hA5A5);
    tick();
    chk("t5_fresh_re",   32'(re_fx),   1);
    chk("t5_fresh_addr", 32'(addr_fx), 32'h0050);
    tick();
    if_fx.req_i[0] = 1'b0;
    tick(3);

    chk("fx_all_completed", 32'(q_fx.size()), 0);
    chk("rr_all_completed", 32'(q_rr.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
